// File: rtl/demux_seq8.sv
// Serialises an 8-bit word onto a 1-to-8 demux: one bit per select value, each held HOLD cycles,
// followed by a one-cycle done pulse. All outputs are registered.
module demux_seq8 #(
    parameter int unsigned HOLD = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       dout,
    output logic [2:0] sel,
    output logic       stb,
    output logic       done,
    output logic       busy
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSend = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [3:0] HoldLast = 4'(HOLD - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] hold_q, hold_d;
    logic [7:0] word_q, word_d;
    logic       send_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        word_d  = word_q;
        case (state_q)
            StIdle: begin
                // din_ready is high exactly in IDLE, so din_valid alone completes the handshake
                if (din_valid) begin
                    word_d  = din;
                    idx_d   = 3'd0;
                    hold_d  = 4'd0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (hold_q == HoldLast) begin
                    hold_d = 4'd0;
                    if (idx_q == 3'd7) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign send_d = (state_d == StSend);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
            hold_q  <= 4'd0;
            word_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            word_q  <= word_d;
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    // The select swizzle matches the downstream demux bit order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout      <= 1'b0;
            sel       <= 3'b000;
            stb       <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            din_ready <= 1'b1;
        end else begin
            dout      <= send_d & word_d[idx_d];
            sel       <= send_d ? {idx_d[2], idx_d[0], idx_d[1]} : sel;
            stb       <= send_d;
            done      <= (state_d == StDone);
            busy      <= (state_d != StIdle);
            din_ready <= (state_d == StIdle);
        end
    end

endmodule
